rgb_to_hsv_stream: RTL

Parametrised, fully pipelined RGB→HSV converter for the vision colour-threshold path. Successor to the fixed 8-bit converter. It adds:
- generic component width and hue scale
- valid/ready backpressure
- packet sideband pass-through (sop/eop)
- an integrated HSV range-match flag

It sits between the pixel source/debayer stage and the blob/threshold logic.

---
 rtl/rgb_to_hsv_stream.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/rgb_to_hsv_stream.sv
// Streaming RGB to HSV converter, 4 register stages, valid/ready.
// Carries sop/eop sideband and flags pixels inside an HSV window.
module rgb_to_hsv_stream #(
  parameter int COMP_W  = 8,
  parameter int HUE_MAX = 360,
  parameter int HUE_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COMP_W-1:0] in_r,
  input  logic [COMP_W-1:0] in_g,
  input  logic [COMP_W-1:0] in_b,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HUE_W-1:0]  out_h,
  output logic [COMP_W-1:0] out_s,
  output logic [COMP_W-1:0] out_v,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_match,
  input  logic              thr_en,
  input  logic [HUE_W-1:0]  thr_h_lo,
  input  logic [HUE_W-1:0]  thr_h_hi,
  input  logic [COMP_W-1:0] thr_s_min,
  input  logic [COMP_W-1:0] thr_v_min
);

  localparam int K   = HUE_MAX / 6;
  localparam int KW  = $clog2(K + 1);
  localparam int PHW = COMP_W + KW;
  localparam int PSW = 2 * COMP_W;

  localparam logic [COMP_W-1:0] C_MAX  = '1;
  localparam logic [HUE_W-1:0]  H_FULL = HUE_W'(HUE_MAX);
  localparam logic [HUE_W-1:0]  H_2K   = HUE_W'(2 * K);
  localparam logic [HUE_W-1:0]  H_4K   = HUE_W'(4 * K);

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_e;

  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // stage 1: max select; a/b are the two non-max channels in hue order
  ch_e              c_ch;
  logic [COMP_W-1:0] c_mx, c_a, c_b;
  logic [COMP_W-1:0] c_top, c_dl;
  logic              c_pos;

  always_comb begin
    c_ch = CH_B;
    c_mx = in_b;
    c_a  = in_r;
    c_b  = in_g;
    if (in_r >= in_g && in_r >= in_b) begin
      c_ch = CH_R;
      c_mx = in_r;
      c_a  = in_g;
      c_b  = in_b;
    end else if (in_g >= in_b) begin
      c_ch = CH_G;
      c_mx = in_g;
      c_a  = in_b;
      c_b  = in_r;
    end
    c_pos = c_a >= c_b;
    c_top = c_pos ? c_a - c_b : c_b - c_a;
    c_dl  = c_mx - (c_pos ? c_b : c_a);
  end

  logic              v1, sop1, eop1, pos1;
  ch_e               ch1;
  logic [COMP_W-1:0] mx1, dl1, top1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      sop1 <= 1'b0;
      eop1 <= 1'b0;
      pos1 <= 1'b0;
      ch1  <= CH_R;
      mx1  <= '0;
      dl1  <= '0;
      top1 <= '0;
    end else if (adv) begin
      v1   <= in_valid;
      sop1 <= in_sop;
      eop1 <= in_eop;
      pos1 <= c_pos;
      ch1  <= c_ch;
      mx1  <= c_mx;
      dl1  <= c_dl;
      top1 <= c_top;
    end
  end

  // stage 2: full-width products
  logic              v2, sop2, eop2, pos2;
  ch_e               ch2;
  logic [COMP_W-1:0] mx2, dl2;
  logic [PHW-1:0]    p_h2;
  logic [PSW-1:0]    p_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      sop2 <= 1'b0;
      eop2 <= 1'b0;
      pos2 <= 1'b0;
      ch2  <= CH_R;
      mx2  <= '0;
      dl2  <= '0;
      p_h2 <= '0;
      p_s2 <= '0;
    end else if (adv) begin
      v2   <= v1;
      sop2 <= sop1;
      eop2 <= eop1;
      pos2 <= pos1;
      ch2  <= ch1;
      mx2  <= mx1;
      dl2  <= dl1;
      p_h2 <= PHW'(top1) * PHW'(K);
      p_s2 <= PSW'(dl1) * PSW'(C_MAX);
    end
  end

  // stage 3: divides; top<=delta keeps h_off within 0..K
  logic [KW-1:0]     d_hoff;
  logic [COMP_W-1:0] d_s;

  always_comb begin
    d_hoff = '0;
    d_s    = '0;
    if (dl2 != '0)
      d_hoff = KW'(p_h2 / PHW'(dl2));
    if (mx2 != '0)
      d_s = COMP_W'(p_s2 / PSW'(mx2));
  end

  logic              v3, sop3, eop3, pos3, zero3;
  ch_e               ch3;
  logic [COMP_W-1:0] mx3, s3;
  logic [KW-1:0]     hoff3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      sop3  <= 1'b0;
      eop3  <= 1'b0;
      pos3  <= 1'b0;
      zero3 <= 1'b0;
      ch3   <= CH_R;
      mx3   <= '0;
      s3    <= '0;
      hoff3 <= '0;
    end else if (adv) begin
      v3    <= v2;
      sop3  <= sop2;
      eop3  <= eop2;
      pos3  <= pos2;
      zero3 <= dl2 == '0;
      ch3   <= ch2;
      mx3   <= mx2;
      s3    <= d_s;
      hoff3 <= d_hoff;
    end
  end

  // stage 4: hue sector assembly and window match
  logic [HUE_W-1:0] h_ext, e_h;
  logic             h_in, e_m;

  always_comb begin
    h_ext = HUE_W'(hoff3);
    e_h   = '0;
    unique case (ch3)
      CH_R: begin
        e_h = pos3 ? h_ext : H_FULL - h_ext;
        if (e_h == H_FULL)
          e_h = '0;
      end
      CH_G:    e_h = pos3 ? H_2K + h_ext : H_2K - h_ext;
      CH_B:    e_h = pos3 ? H_4K + h_ext : H_4K - h_ext;
      default: e_h = '0;
    endcase
    if (zero3)
      e_h = '0;
    if (thr_h_lo <= thr_h_hi)
      h_in = (e_h >= thr_h_lo) && (e_h <= thr_h_hi);
    else
      h_in = (e_h >= thr_h_lo) || (e_h <= thr_h_hi);
    e_m = thr_en & h_in & (s3 >= thr_s_min) & (mx3 >= thr_v_min);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_h     <= '0;
      out_s     <= '0;
      out_v     <= '0;
      out_match <= 1'b0;
    end else if (adv) begin
      out_valid <= v3;
      out_sop   <= sop3;
      out_eop   <= eop3;
      out_h     <= e_h;
      out_s     <= s3;
      out_v     <= mx3;
      out_match <= e_m;
    end
  end

endmodule
